// File: rtl/cmt_reset_sequencer.sv
// Clock tile reset sequencer: pulses the tile reset, qualifies lock,
// then releases the capture, filter and output domain resets in order.
module cmt_reset_sequencer #(
  parameter int CMT_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int STABLE_CYCLES  = 16,
  parameter int RELEASE_GAP    = 4,
  parameter int CNT_W          = 12
) (
  input  logic       CLK_IN1,
  input  logic       RST_N,
  input  logic       LOCKED,
  output logic       CMT_RESET,
  output logic [2:0] DOM_RST_N,
  output logic       READY,
  output logic [3:0] RETRY_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_CMT_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL       = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CMT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lk_q1;
  logic             lk_s;

  assign STATE = state;

  // LOCKED comes from the tile's own clocking; bring it in here
  always_ff @(posedge CLK_IN1 or negedge RST_N) begin
    if (!RST_N) begin
      lk_q1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      lk_q1 <= LOCKED;
      lk_s  <= lk_q1;
    end
  end

  always_ff @(posedge CLK_IN1 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_CMT_RST;
      cnt       <= '0;
      CMT_RESET <= 1'b1;
      DOM_RST_N <= 3'b000;
      READY     <= 1'b0;
      RETRY_CNT <= 4'd0;
    end else begin
      unique case (state)
        S_CMT_RST: begin
          CMT_RESET <= 1'b1;
          if (cnt == RST_LAST) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            CMT_RESET <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            if (RETRY_CNT != 4'hF)
              RETRY_CNT <= RETRY_CNT + 4'd1;
            state     <= S_CMT_RST;
            cnt       <= '0;
            CMT_RESET <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state     <= S_REL;
            cnt       <= '0;
            DOM_RST_N <= 3'b001;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REL: begin
          if (!lk_s) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            DOM_RST_N <= 3'b000;
            READY     <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (!DOM_RST_N[1]) begin
              DOM_RST_N <= 3'b011;
            end else begin
              DOM_RST_N <= 3'b111;
              READY     <= 1'b1;
              state     <= S_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            DOM_RST_N <= 3'b000;
            READY     <= 1'b0;
          end
        end
        default: begin
          state     <= S_CMT_RST;
          cnt       <= '0;
          CMT_RESET <= 1'b1;
          DOM_RST_N <= 3'b000;
          READY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmt_reset_sequencer.sv
// Directed bench for cmt_reset_sequencer: startup, timeout, glitch,
// lock loss, async reset and retry saturation.
module tb_cmt_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       cmt_reset;
  logic [2:0] dom_rst_n;
  logic       ready;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  logic       rst2_n;
  logic       locked2;
  logic       cmt_reset2;
  logic [2:0] dom_rst_n2;
  logic       ready2;
  logic [3:0] retry_cnt2;
  logic [2:0] state2;

  int vec;
  int err;

  cmt_reset_sequencer dut (
    .CLK_IN1   (clk),
    .RST_N     (rst_n),
    .LOCKED    (locked),
    .CMT_RESET (cmt_reset),
    .DOM_RST_N (dom_rst_n),
    .READY     (ready),
    .RETRY_CNT (retry_cnt),
    .STATE     (state)
  );

  cmt_reset_sequencer #(.LOCK_TIMEOUT(4)) dut_sat (
    .CLK_IN1   (clk),
    .RST_N     (rst2_n),
    .LOCKED    (locked2),
    .CMT_RESET (cmt_reset2),
    .DOM_RST_N (dom_rst_n2),
    .READY     (ready2),
    .RETRY_CNT (retry_cnt2),
    .STATE     (state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic lk);
    locked = lk;
    rst_n  = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    locked = 1'b1;
    tick(3);
    vec++;
    if (cmt_reset !== 1'b1 || dom_rst_n !== 3'b000 || ready !== 1'b0 ||
        retry_cnt !== 4'd0 || state !== 3'd0) begin
      err++;
      $display("FAIL reset: cmt=%b dom=%b rdy=%b retry=%0d st=%0d want 1 000 0 0 0",
               cmt_reset, dom_rst_n, ready, retry_cnt, state);
    end
  endtask

  task automatic test_clean_start;
    logic [2:0] es, ed;
    logic       ec, er;
    start(1'b1);
    for (int e = 1; e <= 40; e++) begin
      tick(1);
      ec = (e < 8);
      es = (e < 8) ? 3'd0 : (e == 8) ? 3'd1 : (e < 25) ? 3'd2 :
           (e < 33) ? 3'd3 : 3'd4;
      ed = (e < 25) ? 3'b000 : (e < 29) ? 3'b001 : (e < 33) ? 3'b011 : 3'b111;
      er = (e >= 33);
      vec++;
      if (cmt_reset !== ec || state !== es || dom_rst_n !== ed ||
          ready !== er || retry_cnt !== 4'd0) begin
        err++;
        $display("FAIL clean e%0d: cmt=%b st=%0d dom=%b rdy=%b retry=%0d want %b %0d %b %b 0",
                 e, cmt_reset, state, dom_rst_n, ready, retry_cnt, ec, es, ed, er);
      end
    end
  endtask

  task automatic test_timeout;
    int rises, bad_cmt, bad_dom, first_bad;
    logic prev, ec;
    rises = 0; bad_cmt = 0; bad_dom = 0; first_bad = -1;
    start(1'b0);
    prev = 1'b1;
    for (int e = 1; e <= 2200; e++) begin
      tick(1);
      ec = (e < 8) || (e >= 1032 && e < 1040) || (e >= 2064 && e < 2072);
      if (cmt_reset !== ec) begin
        bad_cmt++;
        if (first_bad < 0) first_bad = e;
      end
      if (dom_rst_n !== 3'b000 || ready !== 1'b0) bad_dom++;
      if (cmt_reset && !prev) rises++;
      prev = cmt_reset;
      if (e == 1031) begin
        vec++;
        if (retry_cnt !== 4'd0) begin
          err++;
          $display("FAIL timeout_pre: retry=%0d want 0", retry_cnt);
        end
      end
      if (e == 1032) begin
        vec++;
        if (retry_cnt !== 4'd1 || state !== 3'd0) begin
          err++;
          $display("FAIL timeout_first: retry=%0d st=%0d want 1 0", retry_cnt, state);
        end
      end
    end
    vec++;
    if (bad_cmt !== 0) begin
      err++;
      $display("FAIL timeout_pulses: %0d bad edges (first e%0d) want 0", bad_cmt, first_bad);
    end
    vec++;
    if (rises !== 2) begin
      err++;
      $display("FAIL timeout_rises: %0d want 2", rises);
    end
    vec++;
    if (retry_cnt !== 4'd2 || bad_dom !== 0) begin
      err++;
      $display("FAIL timeout_end: retry=%0d dom_bad=%0d want 2 0", retry_cnt, bad_dom);
    end
  endtask

  task automatic test_glitch;
    logic [2:0] es, ed;
    start(1'b1);
    tick(19);
    vec++;
    if (state !== 3'd2) begin
      err++;
      $display("FAIL glitch_pre: st=%0d want 2", state);
    end
    locked = 1'b0;
    for (int e = 20; e <= 39; e++) begin
      tick(1);
      if (e == 20) locked = 1'b1;
      es = (e <= 21) ? 3'd2 : (e == 22) ? 3'd1 : (e < 39) ? 3'd2 : 3'd3;
      ed = (e == 39) ? 3'b001 : 3'b000;
      vec++;
      if (state !== es || dom_rst_n !== ed || cmt_reset !== 1'b0 ||
          retry_cnt !== 4'd0) begin
        err++;
        $display("FAIL glitch e%0d: st=%0d dom=%b cmt=%b retry=%0d want %0d %b 0 0",
                 e, state, dom_rst_n, cmt_reset, retry_cnt, es, ed);
      end
    end
  endtask

  task automatic test_lock_loss;
    start(1'b1);
    tick(40);
    vec++;
    if (ready !== 1'b1 || dom_rst_n !== 3'b111) begin
      err++;
      $display("FAIL loss_run: rdy=%b dom=%b want 1 111", ready, dom_rst_n);
    end
    locked = 1'b0;
    tick(2);
    vec++;
    if (ready !== 1'b1 || dom_rst_n !== 3'b111) begin
      err++;
      $display("FAIL loss_sync: rdy=%b dom=%b want 1 111", ready, dom_rst_n);
    end
    tick(1);
    vec++;
    if (ready !== 1'b0 || dom_rst_n !== 3'b000 || cmt_reset !== 1'b0 ||
        state !== 3'd1 || retry_cnt !== 4'd0) begin
      err++;
      $display("FAIL loss_drop: rdy=%b dom=%b cmt=%b st=%0d retry=%0d want 0 000 0 1 0",
               ready, dom_rst_n, cmt_reset, state, retry_cnt);
    end
    tick(2);
    locked = 1'b1;
    tick(18);
    vec++;
    if (dom_rst_n !== 3'b000 || state !== 3'd2) begin
      err++;
      $display("FAIL loss_requal63: dom=%b st=%0d want 000 2", dom_rst_n, state);
    end
    tick(1);
    vec++;
    if (dom_rst_n !== 3'b001) begin
      err++;
      $display("FAIL loss_rel64: dom=%b want 001", dom_rst_n);
    end
    tick(4);
    vec++;
    if (dom_rst_n !== 3'b011 || ready !== 1'b0) begin
      err++;
      $display("FAIL loss_rel68: dom=%b rdy=%b want 011 0", dom_rst_n, ready);
    end
    tick(4);
    vec++;
    if (dom_rst_n !== 3'b111 || ready !== 1'b1 || cmt_reset !== 1'b0) begin
      err++;
      $display("FAIL loss_rel72: dom=%b rdy=%b cmt=%b want 111 1 0",
               dom_rst_n, ready, cmt_reset);
    end
  endtask

  task automatic test_async_reset;
    start(1'b1);
    tick(30);
    vec++;
    if (dom_rst_n !== 3'b011 || state !== 3'd3) begin
      err++;
      $display("FAIL async_pre: dom=%b st=%0d want 011 3", dom_rst_n, state);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vec++;
    if (cmt_reset !== 1'b1 || dom_rst_n !== 3'b000 || ready !== 1'b0 ||
        retry_cnt !== 4'd0 || state !== 3'd0) begin
      err++;
      $display("FAIL async_rst: cmt=%b dom=%b rdy=%b retry=%0d st=%0d want 1 000 0 0 0",
               cmt_reset, dom_rst_n, ready, retry_cnt, state);
    end
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    locked2 = 1'b0;
    rst2_n  = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      tick(1);
      if (e == 11 || e == 12 || e == 36 || e == 168 || e == 180 ||
          e == 204 || e == 300) begin
        vec++;
        if (retry_cnt2 !== 4'((e / 12 > 15) ? 15 : e / 12) ||
            dom_rst_n2 !== 3'b000 || ready2 !== 1'b0) begin
          err++;
          $display("FAIL sat e%0d: retry=%0d dom=%b rdy=%b want %0d 000 0",
                   e, retry_cnt2, dom_rst_n2, ready2, (e / 12 > 15) ? 15 : e / 12);
        end
      end
    end
  endtask

  initial begin
    vec     = 0;
    err     = 0;
    rst_n   = 1'b0;
    locked  = 1'b0;
    rst2_n  = 1'b0;
    locked2 = 1'b0;
    test_reset;
    test_clean_start;
    test_timeout;
    test_glitch;
    test_lock_loss;
    test_async_reset;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
